// File: rtl/pos_tx_pkg.sv
// Shared types and constants for the position-to-remote AXI-Stream transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: packet struct, header field map, state enum and a header builder.
package pos_tx_pkg;

  localparam int NUM_DEST      = 7;    // remote destination indices 0..6
  localparam int DEST_W        = 3;    // dest_idx width carried in a packet
  localparam int POS_PAYLOAD_W = 480;  // default position payload width

  // Header beat field map (low 32 bits of tdata; the rest is zero).
  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam int         HDR_SEQ_LSB   = 0;
  localparam int         HDR_SEQ_W     = 16;
  localparam int         HDR_DEST_LSB  = 16;
  localparam int         HDR_ID_LSB    = 19;
  localparam int         HDR_ID_W      = 4;   // room up to bit 22; bit 23 is last
  localparam int         HDR_LAST_BIT  = 23;
  localparam int         HDR_MAGIC_LSB = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } tx_state_e;

  // Upstream packet layout, MSB first.
  typedef struct packed {
    logic                     vld;
    logic                     last;
    logic [DEST_W-1:0]        dest_idx;
    logic [POS_PAYLOAD_W-1:0] payload;
  } pkt_t;

  function automatic logic [31:0] make_hdr(
    input logic [HDR_SEQ_W-1:0] seq,
    input logic [DEST_W-1:0]    dest,
    input logic [HDR_ID_W-1:0]  node_id,
    input logic                 last
  );
    logic [31:0] h;
    h = '0;
    h[HDR_SEQ_LSB   +: HDR_SEQ_W] = seq;
    h[HDR_DEST_LSB  +: DEST_W]    = dest;
    h[HDR_ID_LSB    +: HDR_ID_W]  = node_id;
    h[HDR_LAST_BIT]               = last;
    h[HDR_MAGIC_LSB +: 8]         = HDR_MAGIC;
    return h;
  endfunction

endpackage

// File: rtl/pos_tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered count and flags.
// Latency: a push is visible at o_head_dat the cycle after the write edge.
// Backpressure: none; a push while full (and not popping) is dropped and flagged on o_drop.
// Ports: i_push/i_push_dat write, i_pop read-advance, o_head_dat head entry,
//        o_next_dat entry that becomes head after a pop, o_count/o_full/o_empty/o_almost_full.
module pos_tx_sync_fifo #(
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  output logic                   o_push_acc,
  output logic                   o_drop,
  output logic [W-1:0]           o_head_dat,
  output logic [W-1:0]           o_next_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic          pop_ok;

  always_comb begin
    pop_ok     = i_pop && !empty_q;
    // A pop frees the slot in the same edge, so push-while-full-and-popping is kept.
    o_push_acc = i_push && (!full_q || pop_ok);
    o_drop     = i_push && !o_push_acc;
    rd_ptr_nxt = rd_ptr_q + AW'(1);
    wr_ptr_d   = o_push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_nxt : rd_ptr_q;
    count_d    = count_q + CW'(o_push_acc) - CW'(pop_ok);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    af_d       = (count_d >= CW'(DEPTH - AF_MARGIN));
  end

  always_ff @(posedge clk) begin
    if (o_push_acc) mem[wr_ptr_q] <= i_push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
    end
  end

  assign o_head_dat    = mem[rd_ptr_q];
  // With one entry left the successor can only be the word being pushed this cycle.
  assign o_next_dat    = (count_q > CW'(1)) ? mem[rd_ptr_nxt] : i_push_dat;
  assign o_count       = count_q;
  assign o_full        = full_q;
  assign o_empty       = empty_q;
  assign o_almost_full = af_q;

endmodule

// File: rtl/pos_to_remote_axis_tx.sv
// Buffers ring position packets and emits them as two-beat (header, payload) AXI-Stream frames.
// Latency: header tvalid 2 cycles after the input packet; payload the cycle after the header handshake.
// Backpressure: full tready stall; upstream has no ready, so o_almost_full throttles and overflow drops.
// Ports: i_pkt {valid,last,dest[2:0],payload}, i_init_id, i_phase_clear; m_axis_* master;
//        o_almost_full, o_empty, o_overflow, o_last_sent/o_all_last_sent, o_frames_sent/o_stall_cycles.
// Optional: define POS_TX_STATS_EN to enable the frame and stall counters (tied to 0 otherwise).
module pos_to_remote_axis_tx
  import pos_tx_pkg::*;
#(
  parameter int NUM_DEST      = 7,
  parameter int NODE_ID_WIDTH = 3,
  parameter int PAYLOAD_WIDTH = POS_PAYLOAD_W,
  parameter int DATA_WIDTH    = 512,
  parameter int FIFO_DEPTH    = 16,
  parameter int AF_MARGIN     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NODE_ID_WIDTH-1:0] i_init_id,
  input  logic [PAYLOAD_WIDTH+4:0] i_pkt,
  input  logic                     i_phase_clear,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [2:0]               m_axis_tdest,
  output logic                     o_almost_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic [NUM_DEST-1:0]      o_last_sent,
  output logic                     o_all_last_sent,
  output logic [31:0]              o_frames_sent,
  output logic [31:0]              o_stall_cycles
);

  localparam int ENT_W   = PAYLOAD_WIDTH + 1 + DEST_W;  // {last, dest, payload}
  localparam int NUM_SEQ = 1 << DEST_W;                 // dest 7 gets its own counter too
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  logic [ENT_W-1:0]         head_dat, next_dat;
  logic [CW-1:0]            fifo_count;
  logic                     fifo_push_acc, fifo_drop, fifo_full, fifo_empty, fifo_af;
  logic                     pop;

  tx_state_e                state_q, state_d;
  logic [DEST_W-1:0]        dest_q, dest_d;
  logic                     last_q, last_d;
  logic [HDR_SEQ_W-1:0]     seq_q [NUM_SEQ];
  logic [HDR_SEQ_W-1:0]     seq_d [NUM_SEQ];
  logic [NUM_DEST-1:0]      last_sent_q, last_sent_d, set_vec;
  logic                     overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0]    tdata_c;
  logic                     tvalid_c, tlast_c;
  logic [2:0]               tdest_c;
  logic [HDR_ID_W-1:0]      id_ext;

  assign id_ext = HDR_ID_W'(i_init_id);

  pos_tx_sync_fifo #(
    .W         (ENT_W),
    .DEPTH     (FIFO_DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_push        (i_pkt[PAYLOAD_WIDTH+4]),
    .i_push_dat    (i_pkt[ENT_W-1:0]),
    .i_pop         (pop),
    .o_push_acc    (fifo_push_acc),
    .o_drop        (fifo_drop),
    .o_head_dat    (head_dat),
    .o_next_dat    (next_dat),
    .o_count       (fifo_count),
    .o_full        (fifo_full),
    .o_empty       (fifo_empty),
    .o_almost_full (fifo_af)
  );

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    last_d     = last_q;
    seq_d      = seq_q;
    pop        = 1'b0;
    set_vec    = '0;
    tvalid_c   = 1'b0;
    tlast_c    = 1'b0;
    tdest_c    = '0;
    tdata_c    = '0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          dest_d  = head_dat[PAYLOAD_WIDTH +: DEST_W];
          last_d  = head_dat[ENT_W-1];
          state_d = HDR;
        end
      end
      HDR: begin
        tvalid_c      = 1'b1;
        tdest_c       = dest_q;
        tdata_c[31:0] = make_hdr(seq_q[dest_q], dest_q, id_ext, last_q);
        if (m_axis_tready) begin
          seq_d[dest_q] = seq_q[dest_q] + 16'd1;
          state_d       = PAY;
        end
      end
      PAY: begin
        tvalid_c                         = 1'b1;
        tlast_c                          = 1'b1;
        tdest_c                          = dest_q;
        tdata_c[PAYLOAD_WIDTH-1:0]       = head_dat[PAYLOAD_WIDTH-1:0];
        if (m_axis_tready) begin
          pop = 1'b1;
          // Out-of-range destinations are sent but never mark completion.
          for (int d = 0; d < NUM_DEST; d++) begin
            if (last_q && (int'(dest_q) == d)) set_vec[d] = 1'b1;
          end
          // Chain straight into the next header so frames have no idle beat between them.
          if ((fifo_count > CW'(1)) || fifo_push_acc) begin
            dest_d  = next_dat[PAYLOAD_WIDTH +: DEST_W];
            last_d  = next_dat[ENT_W-1];
            state_d = HDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A set in the clearing cycle survives for its own bit.
    last_sent_d = i_phase_clear ? set_vec : (last_sent_q | set_vec);
    overflow_d  = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dest_q      <= '0;
      last_q      <= 1'b0;
      last_sent_q <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < NUM_SEQ; i++) seq_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      last_q      <= last_d;
      last_sent_q <= last_sent_d;
      overflow_q  <= overflow_d;
      seq_q       <= seq_d;
    end
  end

  assign m_axis_tdata    = tdata_c;
  assign m_axis_tvalid   = tvalid_c;
  assign m_axis_tlast    = tlast_c;
  assign m_axis_tdest    = tdest_c;
  assign o_almost_full   = fifo_af;
  // Both terms are flops, so this follows the count and state after each edge.
  assign o_empty         = fifo_empty && (state_q == IDLE);
  assign o_overflow      = overflow_q;
  assign o_last_sent     = last_sent_q;
  assign o_all_last_sent = &last_sent_q;

`ifdef POS_TX_STATS_EN
  logic [31:0] frames_q, frames_d, stall_q, stall_d;

  always_comb begin
    frames_d = frames_q;
    stall_d  = stall_q;
    if ((state_q == PAY) && m_axis_tready) frames_d = frames_q + 32'd1;
    if (tvalid_c && !m_axis_tready)        stall_d  = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      stall_q  <= '0;
    end else begin
      frames_q <= frames_d;
      stall_q  <= stall_d;
    end
  end

  assign o_frames_sent  = frames_q;
  assign o_stall_cycles = stall_q;
`else
  assign o_frames_sent  = '0;
  assign o_stall_cycles = '0;
`endif

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/pos_to_remote_axis_tx.md
Name: pos_to_remote_axis_tx

Overview:
- Sits directly downstream of the ring position-to-remote controller chain.
- Consumes its registered per-cycle packet output, which has no ready and carries a valid bit in the MSB, and buffers it in an internal FIFO.
- Emits two-beat network frames, header beat then payload beat, on an AXI4-Stream master with full tready backpressure toward the inter-FPGA transport.
- Tracks per-destination sequence numbers and last-position completion for the phase controller.

Parameters:
- NUM_DEST, 7, number of remote destination indices, 0..6.
- NODE_ID_WIDTH, 3, width of a node id.
- PAYLOAD_WIDTH, 480, width of the position payload carried in an input packet.
- DATA_WIDTH, 512, AXI-Stream tdata width; must be at least PAYLOAD_WIDTH and at least 32.
- FIFO_DEPTH, 16, input FIFO entries; must be a power of 2.
- AF_MARGIN, 4, o_almost_full asserts when count >= FIFO_DEPTH-AF_MARGIN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- i_init_id  in  NODE_ID_WIDTH  local node id, inserted in the header.
- i_pkt  in  PAYLOAD_WIDTH+5  {valid, last, dest_idx[2:0], payload}.
- i_phase_clear  in  1  one-cycle pulse; clears o_last_sent.
- m_axis_tdata  out  DATA_WIDTH  frame beat data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  beat accepted.
- m_axis_tlast  out  1  high on the payload beat.
- m_axis_tdest  out  3  dest_idx of the current frame.
- o_almost_full  out  1  FIFO at or above threshold; upstream throttle.
- o_empty  out  1  FIFO empty and FSM in IDLE.
- o_overflow  out  1  sticky flag: a packet was dropped.
- o_last_sent  out  NUM_DEST  per-destination bit: last-flagged payload has been transmitted.
- o_all_last_sent  out  1  AND of o_last_sent.

Behaviour:
- Reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0 except o_empty=1. FIFO is emptied, FSM goes to IDLE, sequence counters are 0.
- Reset mid-frame: tvalid drops immediately. A truncated frame is the transport's responsibility.
- Write path: i_pkt[MSB]=1 pushes {last, dest_idx, payload} into the FIFO.
  - Push while full is discarded and o_overflow is set. It clears only on reset.
  - Simultaneous push and pop while full is accepted; count is unchanged.
- FSM IDLE:
  - If the FIFO is not empty, latch the head dest_idx and last flag, then go to HDR.
  - Earliest header tvalid is 2 cycles after the input valid.
- FSM HDR:
  - tvalid=1, tlast=0, tdest=latched dest.
  - tdata fields: [15:0]=seq[dest], [18:16]=dest, [18+NODE_ID_WIDTH:19]=i_init_id, [23]=last, [31:24]=8'hA5, remaining bits 0.
  - On handshake: seq[dest] += 1 (wraps 16'hFFFF->0), go to PAY.
- FSM PAY:
  - tvalid=1, tlast=1, tdata = zero-extended head payload.
  - On handshake: pop the FIFO; if last is set, set o_last_sent[dest]. Then go to HDR if the FIFO will still be non-empty after the pop, else IDLE.
  - Back-to-back frames therefore have no idle beats.
- AXIS rules:
  - Once tvalid is high, tdata, tdest and tlast are held stable until tready.
  - tvalid is never withdrawn before the handshake.
  - tready is ignored outside HDR and PAY.
- i_phase_clear clears all o_last_sent bits. If a set occurs in the same cycle, the set wins for that bit.
- FIFO count is registered. o_almost_full and o_empty are registered, reflecting the count after the current edge.
- dest_idx of 7 or more is transmitted normally, but o_last_sent is not updated.

Optional Feature:
- POS_TX_STATS_EN defined adds outputs o_frames_sent[31:0] and o_stall_cycles[31:0], both free-running, wrapping, and reset to 0.
  - o_frames_sent increments on each payload handshake.
  - o_stall_cycles increments on each cycle with tvalid=1 and tready=0.
- POS_TX_STATS_EN undefined: the ports are still present and tied to 0. No counter logic is instantiated.

Decomposition:
- Shared package pos_tx_pkg:
  - pkt_t struct (valid, last, dest_idx, payload).
  - hdr constants: HDR_MAGIC=8'hA5 and the field bit positions.
  - NUM_DEST and the state enum {IDLE, HDR, PAY}.
- One sub-module, pos_tx_sync_fifo: a parameterised FWFT synchronous FIFO with count, full, empty and almost_full.

Test Plan:
- Single packet {last=0, dest=2, payload=0x1234}, tready=1:
  - header appears 2 cycles after input with tdata[31:0]=0xA5000000|(id<<19)|(2<<16)|0 and tdest=2.
  - next cycle, payload 0x1234 with tlast=1.
  - o_empty returns to 1.
- Three packets to dest 5 back-to-back, tready=1:
  - 6 contiguous beats, headers carry seq 0, 1, 2, and no bubble between frames.
- tready held 0 for 10 cycles during PAY:
  - tdata and tvalid stay stable.
  - o_stall_cycles=10 (STATS_EN).
  - the frame completes when tready rises.
- 20 pushes with tready=0:
  - o_almost_full asserts at count 12.
  - 4 packets are dropped and o_overflow=1.
  - draining yields exactly 16 frames.
- Last-flagged packets to dests 0..6:
  - o_all_last_sent=1 after the 7th payload handshake.
  - i_phase_clear in the same cycle as a dest-3 last handshake leaves only bit 3 set.
- rst_n asserted mid-header with a FIFO holding 5 entries:
  - tvalid=0 immediately and o_empty=1.
  - seq counters return to 0 and the next frame header shows seq=0.
